// File: rtl/lfsr65_pkg.sv
// Shared constants, state type and helpers for the 65-bit LFSR pattern checker.
package lfsr65_pkg;

    localparam int unsigned LfsrBits = 65;
    localparam int unsigned TapLong  = 65;
    localparam int unsigned TapShort = 47;
    localparam int unsigned TapGap   = TapLong - TapShort;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HUNT = 2'd1,
        LOCK = 2'd2
    } state_t;

    // Beats needed before the history register holds 65 genuine stream bits.
    function automatic int unsigned fill_beats(input int unsigned data_bits);
        return (LfsrBits + data_bits - 1) / data_bits;
    endfunction

endpackage

// File: rtl/lfsr65_err_tally.sv
// Popcount stage and saturating error/beat/lock-loss counters; clear drops work in flight.
module lfsr65_err_tally
    import lfsr65_pkg::*;
#(
    parameter int unsigned DataBits = 32,
    parameter int unsigned CntBits  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                err_valid,
    input  logic [DataBits-1:0] err_bits,
    input  logic                lock_lost,
    output logic [CntBits-1:0]  err_count,
    output logic [CntBits-1:0]  beat_count,
    output logic [15:0]         lock_loss_count
);

    localparam int unsigned PcW  = $clog2(DataBits + 1);
    localparam int unsigned SumW = ((CntBits > PcW) ? CntBits : PcW) + 1;
    localparam logic [SumW-1:0] CntMax = SumW'({CntBits{1'b1}});

    logic [PcW-1:0]  pc_c;
    logic [PcW-1:0]  pc;
    logic            pc_valid;
    logic            pc_loss;
    logic [SumW-1:0] err_sum;

    always_comb begin
        pc_c = '0;
        for (int j = 0; j < DataBits; j++) begin
            pc_c = pc_c + PcW'(err_bits[j]);
        end
    end

    assign err_sum = SumW'(err_count) + SumW'(pc);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pc              <= '0;
            pc_valid        <= 1'b0;
            pc_loss         <= 1'b0;
            err_count       <= '0;
            beat_count      <= '0;
            lock_loss_count <= '0;
        end else begin
            pc       <= pc_c;
            pc_valid <= err_valid;
            pc_loss  <= lock_lost;
            if (pc_valid) begin
                err_count <= (err_sum > CntMax) ? '1 : CntBits'(err_sum);
                if (beat_count != '1) begin
                    beat_count <= beat_count + 1'b1;
                end
            end
            if (pc_loss && (lock_loss_count != '1)) begin
                lock_loss_count <= lock_loss_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lfsr65_check.sv
// Self-synchronising receive checker for the s[i] = s[i-65] ^ s[i-47] test pattern.
module lfsr65_check
    import lfsr65_pkg::*;
#(
    parameter int unsigned DataBits    = 32,
    parameter int unsigned LockBeats   = 4,
    parameter int unsigned UnlockBeats = 4,
    parameter int unsigned CntBits     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DataBits-1:0] in_data,
    input  logic                clear,
    output logic                locked,
    output logic                err_valid,
    output logic [DataBits-1:0] err_bits,
    output logic [CntBits-1:0]  err_count,
    output logic [CntBits-1:0]  beat_count,
    output logic [15:0]         lock_loss_count
);

    localparam int unsigned ExtBits   = DataBits + LfsrBits;
    localparam int unsigned FillBeats = fill_beats(DataBits);
    localparam int unsigned FillW     = $clog2(FillBeats + 1);
    localparam int unsigned RunMax    = (LockBeats > UnlockBeats) ? LockBeats : UnlockBeats;
    localparam int unsigned RunW      = $clog2(RunMax + 1);

    state_t              state;
    logic [LfsrBits-1:0] hist;
    logic [FillW-1:0]    fill_cnt;
    logic [RunW-1:0]     run_cnt;
    logic                lock_lost;

    logic [ExtBits-1:0]  rx_ext;
    logic [ExtBits-1:0]  p_ext;
    logic [DataBits-1:0] exp_rx;
    logic [DataBits-1:0] mismatch;
    logic [DataBits-1:0] lock_err;

    // Received-chain check and free-running prediction, both seeded from hist.
    always_comb begin
        rx_ext = {in_data, hist};
        p_ext  = {{DataBits{1'b0}}, hist};
        exp_rx = '0;
        for (int j = 0; j < DataBits; j++) begin
            exp_rx[j]             = rx_ext[j] ^ rx_ext[j + TapGap];
            p_ext[LfsrBits + j]   = p_ext[j] ^ p_ext[j + TapGap];
        end
        mismatch = in_data ^ exp_rx;
        lock_err = in_data ^ p_ext[ExtBits-1:LfsrBits];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            hist      <= '0;
            fill_cnt  <= '0;
            run_cnt   <= '0;
            locked    <= 1'b0;
            err_valid <= 1'b0;
            err_bits  <= '0;
            lock_lost <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            lock_lost <= 1'b0;
            if (in_valid) begin
                unique case (state)
                    FILL: begin
                        hist <= rx_ext[ExtBits-1:DataBits];
                        if (fill_cnt == FillW'(FillBeats - 1)) begin
                            state    <= HUNT;
                            fill_cnt <= '0;
                            run_cnt  <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                    HUNT: begin
                        hist <= rx_ext[ExtBits-1:DataBits];
                        if (mismatch != '0) begin
                            run_cnt <= '0;
                        end else if (run_cnt == RunW'(LockBeats - 1)) begin
                            state   <= LOCK;
                            locked  <= 1'b1;
                            run_cnt <= '0;
                        end else begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end
                    LOCK: begin
                        // Prediction feeds back so each corrupted bit is counted once.
                        hist      <= p_ext[ExtBits-1:DataBits];
                        err_valid <= 1'b1;
                        err_bits  <= lock_err;
                        if (lock_err == '0) begin
                            run_cnt <= '0;
                        end else if (run_cnt == RunW'(UnlockBeats - 1)) begin
                            state     <= FILL;
                            locked    <= 1'b0;
                            run_cnt   <= '0;
                            fill_cnt  <= '0;
                            lock_lost <= 1'b1;
                        end else begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state  <= FILL;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    lfsr65_err_tally #(
        .DataBits (DataBits),
        .CntBits  (CntBits)
    ) u_tally (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .err_valid       (err_valid),
        .err_bits        (err_bits),
        .lock_lost       (lock_lost),
        .err_count       (err_count),
        .beat_count      (beat_count),
        .lock_loss_count (lock_loss_count)
    );

endmodule
